// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction control-step sequencer.
//   - state_t      : control step encoding (IDLE, T0..T5)
//   - OP_*         : supported ALU opcodes (IR[31:27])
//   - *_SEL        : fixed bus source select codes used by the fetch/execute steps
//   - *_LSB        : bit positions of the IR fields
//   - reg_onehot   : ra -> one-hot register load enable
//   - op_legal     : opcode support check
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;

    localparam logic [4:0] ZLO_SEL = 5'd19;
    localparam logic [4:0] PC_SEL  = 5'd20;
    localparam logic [4:0] MDR_SEL = 5'd21;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    function automatic logic [15:0] reg_onehot(input logic [3:0] r);
        logic [15:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // The four supported opcodes are exactly those with the top three bits clear.
    function automatic logic op_legal(input logic [4:0] op);
        return (op[4:2] == 3'b000);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: control-step sequencer for the 32-bit bus datapath.
// Each accepted start runs fetch (T0-T2) then a register-register ALU
// execute (T3-T5).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start, all outputs low
// T0    | PC -> bus, load MAR, increment PC into Z
// T1    | Zlow -> bus, memory read into MDR; waits for mem_rdy
// T2    | MDR -> bus, load IR; unsupported opcode returns to IDLE
// T3    | R[rb] -> bus, load Y
// T4    | R[rc] -> bus, ALU op, load Z
// T5    | Zlow -> bus, load R[ra], done; start here chains to T0
//
// Ports:
//   clk, clr                   clock, async active-high reset
//   start                      instruction request (IDLE/T5 only)
//   IR[31:0]                   instruction register contents
//   mem_rdy                    memory read data valid
//   BusMuxSel[SELW-1:0]        bus source select
//   Rin[NREG-1:0]              one-hot register load enables
//   Read..IncPC                datapath strobes
//   ADD/SUB/AND/OR             ALU operation strobes
//   busy, done, illegal        status
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int NREG = 16,
    parameter int SELW = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [31:0]     IR,
    input  logic            mem_rdy,
    output logic [SELW-1:0] BusMuxSel,
    output logic [NREG-1:0] Rin,
    output logic            Read,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            MARin,
    output logic            PCin,
    output logic            IncPC,
    output logic            ADD,
    output logic            SUB,
    output logic            AND,
    output logic            OR,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    state_t state;
    state_t nxt;

    logic [4:0] op_q;
    logic [3:0] ra_q;
    logic [3:0] rc_q;
    logic       pcin_q;
    logic       ir_legal;

    logic unused_ir;
    assign unused_ir = ^IR[RC_LSB-1:0];

    assign ir_legal = op_legal(IR[OP_LSB +: 5]);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? S_T0 : S_IDLE;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = mem_rdy ? S_T2 : S_T1;
            S_T2:    nxt = ir_legal ? S_T3 : S_IDLE;
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = start ? S_T0 : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they belong to; the async clear zeroes them without a clock.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rc_q      <= '0;
            BusMuxSel <= '0;
            Rin       <= '0;
            Read      <= 1'b0;
            MDRin     <= 1'b0;
            IRin      <= 1'b0;
            Yin       <= 1'b0;
            Zin       <= 1'b0;
            MARin     <= 1'b0;
            pcin_q    <= 1'b0;
            IncPC     <= 1'b0;
            ADD       <= 1'b0;
            SUB       <= 1'b0;
            AND       <= 1'b0;
            OR        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= nxt;

            // Fields are captured as the instruction is loaded, so the execute
            // steps are immune to IR changes once T3 is entered.
            if (state == S_T2) begin
                op_q <= IR[OP_LSB +: 5];
                ra_q <= IR[RA_LSB +: 4];
                rc_q <= IR[RC_LSB +: 4];
            end

            BusMuxSel <= '0;
            Rin       <= '0;
            Read      <= 1'b0;
            MDRin     <= 1'b0;
            IRin      <= 1'b0;
            Yin       <= 1'b0;
            Zin       <= 1'b0;
            MARin     <= 1'b0;
            pcin_q    <= 1'b0;
            IncPC     <= 1'b0;
            ADD       <= 1'b0;
            SUB       <= 1'b0;
            AND       <= 1'b0;
            OR        <= 1'b0;
            done      <= 1'b0;
            busy      <= (nxt != S_IDLE);

            case (nxt)
                S_T0: begin
                    BusMuxSel <= SELW'(PC_SEL);
                    MARin     <= 1'b1;
                    IncPC     <= 1'b1;
                    Zin       <= 1'b1;
                end
                S_T1: begin
                    BusMuxSel <= SELW'(ZLO_SEL);
                    Read      <= 1'b1;
                    MDRin     <= 1'b1;
                    pcin_q    <= 1'b1;
                end
                S_T2: begin
                    BusMuxSel <= SELW'(MDR_SEL);
                    IRin      <= 1'b1;
                end
                S_T3: begin
                    // Entered from T2 on this edge: rb is taken straight from IR.
                    BusMuxSel <= SELW'(IR[RB_LSB +: 4]);
                    Yin       <= 1'b1;
                end
                S_T4: begin
                    BusMuxSel <= SELW'(rc_q);
                    Zin       <= 1'b1;
                    case (op_q)
                        OP_ADD:  ADD <= 1'b1;
                        OP_SUB:  SUB <= 1'b1;
                        OP_AND:  AND <= 1'b1;
                        OP_OR:   OR  <= 1'b1;
                        default: ;
                    endcase
                end
                S_T5: begin
                    BusMuxSel <= SELW'(ZLO_SEL);
                    Rin       <= NREG'(reg_onehot(ra_q));
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // PC loads only in the T1 exit cycle so a memory stall never reloads it.
    assign PCin    = pcin_q & mem_rdy;
    assign illegal = (state == S_T2) && !ir_legal;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] IR;
    logic        mem_rdy;
    logic [4:0]  BusMuxSel;
    logic [15:0] Rin;
    logic        Read, MDRin, IRin, Yin, Zin, MARin, PCin, IncPC;
    logic        ADD, SUB, AND, OR;
    logic        busy, done, illegal;

    instr_sequencer #(.NREG(16), .SELW(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .IR        (IR),
        .mem_rdy   (mem_rdy),
        .BusMuxSel (BusMuxSel),
        .Rin       (Rin),
        .Read      (Read),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .MARin     (MARin),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .ADD       (ADD),
        .SUB       (SUB),
        .AND       (AND),
        .OR        (OR),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int BUSY = 1 << 14;
    localparam int DONE = 1 << 13;
    localparam int ILL  = 1 << 12;
    localparam int FADD = 1 << 11;
    localparam int FSUB = 1 << 10;
    localparam int FAND = 1 << 9;
    localparam int FOR  = 1 << 8;
    localparam int RD   = 1 << 7;
    localparam int MDRI = 1 << 6;
    localparam int IRI  = 1 << 5;
    localparam int YI   = 1 << 4;
    localparam int ZI   = 1 << 3;
    localparam int MARI = 1 << 2;
    localparam int PCI  = 1 << 1;
    localparam int INC  = 1 << 0;

    localparam int F_T0   = BUSY | MARI | INC | ZI;
    localparam int F_T1W  = BUSY | RD | MDRI;
    localparam int F_T1   = BUSY | RD | MDRI | PCI;
    localparam int F_T2   = BUSY | IRI;
    localparam int F_T3   = BUSY | YI;
    localparam int F_T4   = BUSY | ZI;
    localparam int F_T5   = BUSY | DONE;

    // opcode | ra | rb | rc
    localparam logic [31:0] IR_AND_5_2_6 = 32'h1293_0000; // AND R5,R2,R6
    localparam logic [31:0] IR_ADD_1_3_4 = 32'h009A_0000; // ADD R1,R3,R4
    localparam logic [31:0] IR_SUB_7_8_9 = 32'h0BC4_8000; // SUB R7,R8,R9
    localparam logic [31:0] IR_BAD       = 32'hF800_0000; // opcode 11111

    logic [14:0] flags;
    assign flags = {busy, done, illegal, ADD, SUB, AND, OR,
                    Read, MDRin, IRin, Yin, Zin, MARin, PCin, IncPC};

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int esel, input int erin, input int eflags);
        chk($sformatf("%s sel", tag), 32'(BusMuxSel), esel);
        chk($sformatf("%s rin", tag), 32'(Rin), erin);
        chk($sformatf("%s flags", tag), 32'(flags), eflags);
    endtask

    // One clock cycle: drive start/mem_rdy for this cycle, then check outputs.
    task automatic cyc(input string tag, input logic st, input logic mr,
                       input int esel, input int erin, input int eflags);
        @(posedge clk);
        #1;
        start   = st;
        mem_rdy = mr;
        #1;
        chk_outputs(tag, esel, erin, eflags);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr     = 1'b1;
        start   = 1'b0;
        mem_rdy = 1'b1;
        IR      = '0;
        #2;
        chk_outputs("reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // AND R5,R2,R6, memory ready
        IR = IR_AND_5_2_6;
        cyc("and c0", 1, 1, 0, 0, 0);
        cyc("and c1", 0, 1, 20, 0, F_T0);
        cyc("and c2", 0, 1, 19, 0, F_T1);
        cyc("and c3", 0, 1, 21, 0, F_T2);
        cyc("and c4", 0, 1, 2, 0, F_T3);
        cyc("and c5", 0, 1, 6, 0, F_T4 | FAND);
        cyc("and c6", 0, 1, 19, 16'h0020, F_T5);
        cyc("and c7", 0, 1, 0, 0, 0);

        // ADD R1,R3,R4 with three stall cycles in T1
        IR = IR_ADD_1_3_4;
        cyc("stall c0", 1, 0, 0, 0, 0);
        cyc("stall c1", 0, 0, 20, 0, F_T0);
        cyc("stall c2", 0, 0, 19, 0, F_T1W);
        cyc("stall c3", 0, 0, 19, 0, F_T1W);
        cyc("stall c4", 0, 0, 19, 0, F_T1W);
        cyc("stall c5", 0, 1, 19, 0, F_T1);
        cyc("stall c6", 0, 1, 21, 0, F_T2);
        cyc("stall c7", 0, 1, 3, 0, F_T3);
        cyc("stall c8", 0, 1, 4, 0, F_T4 | FADD);
        cyc("stall c9", 0, 1, 19, 16'h0002, F_T5);
        cyc("stall c10", 0, 1, 0, 0, 0);

        // Back-to-back ADD then SUB with start held high
        IR = IR_ADD_1_3_4;
        cyc("b2b c0", 1, 1, 0, 0, 0);
        cyc("b2b c1", 1, 1, 20, 0, F_T0);
        cyc("b2b c2", 1, 1, 19, 0, F_T1);
        cyc("b2b c3", 1, 1, 21, 0, F_T2);
        cyc("b2b c4", 1, 1, 3, 0, F_T3);
        IR = IR_SUB_7_8_9;
        cyc("b2b c5", 1, 1, 4, 0, F_T4 | FADD);
        cyc("b2b c6", 1, 1, 19, 16'h0002, F_T5);
        cyc("b2b c7", 1, 1, 20, 0, F_T0);
        cyc("b2b c8", 1, 1, 19, 0, F_T1);
        cyc("b2b c9", 1, 1, 21, 0, F_T2);
        cyc("b2b c10", 1, 1, 8, 0, F_T3);
        cyc("b2b c11", 1, 1, 9, 0, F_T4 | FSUB);
        cyc("b2b c12", 0, 1, 19, 16'h0080, F_T5);
        cyc("b2b c13", 0, 1, 0, 0, 0);

        // Unsupported opcode aborts from T2
        IR = IR_BAD;
        cyc("ill c0", 1, 1, 0, 0, 0);
        cyc("ill c1", 0, 1, 20, 0, F_T0);
        cyc("ill c2", 0, 1, 19, 0, F_T1);
        cyc("ill c3", 0, 1, 21, 0, F_T2 | ILL);
        cyc("ill c4", 0, 1, 0, 0, 0);
        cyc("ill c5", 0, 1, 0, 0, 0);

        // start during T2 is ignored
        IR = IR_AND_5_2_6;
        cyc("ign c0", 1, 1, 0, 0, 0);
        cyc("ign c1", 0, 1, 20, 0, F_T0);
        cyc("ign c2", 0, 1, 19, 0, F_T1);
        cyc("ign c3", 1, 1, 21, 0, F_T2);
        cyc("ign c4", 0, 1, 2, 0, F_T3);
        cyc("ign c5", 0, 1, 6, 0, F_T4 | FAND);
        cyc("ign c6", 0, 1, 19, 16'h0020, F_T5);
        cyc("ign c7", 0, 1, 0, 0, 0);
        cyc("ign c8", 0, 1, 0, 0, 0);

        // Reset asserted in T3 clears outputs without a clock edge
        IR = IR_OR_placeholder();
        cyc("rst c0", 1, 1, 0, 0, 0);
        cyc("rst c1", 0, 1, 20, 0, F_T0);
        cyc("rst c2", 0, 1, 19, 0, F_T1);
        cyc("rst c3", 0, 1, 21, 0, F_T2);
        cyc("rst c4", 0, 1, 5, 0, F_T3);
        #1;
        clr = 1'b1;
        #1;
        chk_outputs("rst async", 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("rst held", 0, 0, 0);
        clr = 1'b0;
        cyc("rst post0", 0, 1, 0, 0, 0);
        cyc("rst post1", 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // OR R4,R5,R1: opcode 00011, ra 4, rb 5, rc 1 -> 0x1A28_8000
    function automatic logic [31:0] IR_OR_placeholder();
        return 32'h1A28_8000;
    endfunction

endmodule
